// File: rtl/microseq_next_addr.sv
// -----------------------------------------------------------------------------
// microseq_next_addr
//
// Next-address generator for a microprogram sequencer with a small return
// stack.
//
// On every rising clk with en=1, the sequencer picks a next microaddress and
// loads it into state. A 3-bit next-state code (ns) and a selected, optionally
// inverted, status condition choose where that address comes from:
//   - the instruction encoder
//   - zero
//   - the pipeline register
//   - the incrementer (state+1)
//   - the top of the return stack
// A call pushes state+1 on jumps to the encoder or pipeline target.
// Stack overflow and underflow set a sticky error flag.
//
// Ports
//   clk        in   system clock, rising edge
//   clr        in   asynchronous active-low reset
//   en         in   advance enable; 0 holds every register
//   ns         in   [2:0] next-state code
//   cond_sel   in   [log2(NCOND)-1:0] selects the tested condition bit
//   inv        in   inverts the selected condition
//   cond       in   [NCOND-1:0] status condition vector
//   call       in   push a return address on an encoder/pipeline jump
//   enc_addr   in   [AW-1:0] encoder target
//   pipe_addr  in   [AW-1:0] pipeline target
//   state      out  [AW-1:0] registered current microaddress
//   m          out  [2:0] source select (combinational)
//                   000 encoder, 001 zero, 010 pipeline, 011 incr, 100 stack
//   sp         out  [log2(DEPTH):0] stack occupancy, 0..DEPTH
//   full       out  sp == DEPTH
//   empty      out  sp == 0
//   err        out  sticky overflow/underflow flag, cleared only by clr
// -----------------------------------------------------------------------------
module microseq_next_addr #(
  parameter int AW    = 8,
  parameter int NCOND = 4,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(NCOND),
  localparam int IW   = $clog2(DEPTH),
  localparam int SPW  = IW + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       ns,
  input  logic [CW-1:0]    cond_sel,
  input  logic             inv,
  input  logic [NCOND-1:0] cond,
  input  logic             call,
  input  logic [AW-1:0]    enc_addr,
  input  logic [AW-1:0]    pipe_addr,
  output logic [AW-1:0]    state,
  output logic [2:0]       m,
  output logic [SPW-1:0]   sp,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam logic [2:0] M_ENC  = 3'b000;
  localparam logic [2:0] M_ZERO = 3'b001;
  localparam logic [2:0] M_PIPE = 3'b010;
  localparam logic [2:0] M_INC  = 3'b011;
  localparam logic [2:0] M_STK  = 3'b100;

  logic [AW-1:0] stk [DEPTH];
  logic          sts;
  logic [AW-1:0] state_inc;
  logic [IW-1:0] top_idx;
  logic [AW-1:0] top;
  logic          is_empty;
  logic          is_full;
  logic          do_pop;
  logic          do_push;
  logic [AW-1:0] next_state;

  assign sts = cond[cond_sel] ^ inv;

  // Source select decode
  always_comb begin
    m = M_ENC;
    case (ns)
      3'b000:  m = M_ENC;
      3'b001:  m = M_ZERO;
      3'b010:  m = M_PIPE;
      3'b011:  m = M_INC;
      3'b100:  m = sts ? M_PIPE : M_ENC;
      3'b101:  m = sts ? M_PIPE : M_INC;
      3'b110:  m = sts ? M_ENC  : M_INC;
      default: m = sts ? M_PIPE : M_STK;
    endcase
  end

  assign state_inc = state + AW'(1);
  assign is_empty  = (sp == '0);
  assign is_full   = (sp == SPW'(DEPTH));

  // With sp == DEPTH the low IW bits are zero, so the subtraction wraps to
  // DEPTH-1, which is the correct top slot. When sp == 0 the slot is
  // meaningless; every use of it is guarded by is_empty.
  assign top_idx = sp[IW-1:0] - IW'(1);
  assign top     = stk[top_idx];

  assign do_pop  = en && (m == M_STK);
  assign do_push = en && call && ((m == M_ENC) || (m == M_PIPE));

  // Next-address mux. An underflowing pop returns to address 0.
  always_comb begin
    next_state = '0;
    case (m)
      M_ENC:   next_state = enc_addr;
      M_ZERO:  next_state = '0;
      M_PIPE:  next_state = pipe_addr;
      M_INC:   next_state = state_inc;
      M_STK:   next_state = is_empty ? '0 : top;
      default: next_state = '0;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= '0;
      sp    <= '0;
      err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stk[i] <= '0;
      end
    end else if (en) begin
      state <= next_state;
      if (do_pop) begin
        if (is_empty) begin
          // Underflow. A simultaneous call is dropped: there is no frame to
          // overwrite for a tail return.
          err <= 1'b1;
        end else if (call) begin
          // Tail return: replace the frame we return through, sp unchanged.
          stk[top_idx] <= state_inc;
        end else begin
          sp <= sp - SPW'(1);
        end
      end else if (do_push) begin
        if (is_full) begin
          err <= 1'b1;
        end else begin
          stk[sp[IW-1:0]] <= state_inc;
          sp              <= sp + SPW'(1);
        end
      end
    end
  end

  assign full  = is_full;
  assign empty = is_empty;

endmodule

// File: doc/microseq_next_addr.md
MICROSEQ_NEXT_ADDR -- requirements
Module: microseq_next_addr

Interface
REQ-001 Parameter AW, default 8: microaddress width in bits, at least 4.
REQ-002 Parameter NCOND, default 4: number of status condition inputs, a power of 2, at least 2.
REQ-003 Parameter DEPTH, default 4: return stack depth, a power of 2, at least 2.
REQ-004 Clk  in  1  system clock; all registers update on the rising edge.
REQ-005 Clr  in  1  asynchronous, active-low reset.
REQ-006 En  in  1  advance enable; when 0 all registers hold.
REQ-007 NS  in  3  next-state code from the current microinstruction.
REQ-008 CondSel  in  log2(NCOND)  selects the tested condition.
REQ-009 Inv  in  1  inverts the selected condition.
REQ-010 Cond  in  NCOND  status condition vector.
REQ-011 Call  in  1  pushes a return address on a jump.
REQ-012 EncAddr  in  AW  target from the instruction encoder.
REQ-013 PipeAddr  in  AW  target from the pipeline register.
REQ-014 State  out  AW  registered current microaddress.
REQ-015 M  out  3  combinational source select: 000 encoder, 001 zero, 010 pipeline, 011 incrementer, 100 return stack.
REQ-016 SP  out  log2(DEPTH)+1  stack occupancy, from 0 to DEPTH.
REQ-017 Full / Empty  out  1 each  SP==DEPTH / SP==0.
REQ-018 Err  out  1  sticky stack overflow or underflow flag.

Function
REQ-019 Sts SHALL equal Cond[CondSel] XOR Inv, combinationally.
REQ-020 M SHALL be decoded from NS and Sts as follows:
- 000 -> encoder
- 001 -> zero
- 010 -> pipeline
- 011 -> incrementer
- 100 -> Sts ? pipeline : encoder
- 101 -> Sts ? pipeline : incrementer
- 110 -> Sts ? encoder : incrementer
- 111 -> Sts ? pipeline : return stack (pop)
REQ-021 Next state SHALL be:
- encoder -> EncAddr
- zero -> 0
- pipeline -> PipeAddr
- incrementer -> State+1, modulo 2^AW, so all-ones wraps to 0
- return stack -> top entry
REQ-022 On each rising Clk with En=1, State SHALL load the next state; latency is one cycle from the inputs to State.
REQ-023 A push SHALL occur when En=1, Call=1, and M is encoder or pipeline; the pushed value is State+1 (mod 2^AW), and SP increments.
REQ-024 When Call=1 and M is zero, incrementer or return stack, no push SHALL occur, except the case in REQ-027.
REQ-025 A pop SHALL occur when En=1 and M=100: State loads the top entry and SP decrements.
REQ-026 Pop on empty (underflow): State SHALL load 0, SP stays 0, Err sets.
REQ-027 Pop with Call=1 in the same cycle: State SHALL load the old top, the top is overwritten with State+1, and SP is unchanged (tail return).
REQ-028 Push on full (overflow): State SHALL still load the jump target, the stack and SP stay unchanged, and Err sets.
REQ-029 Err SHALL stay set until Clr is asserted; it is never cleared by En or by normal operation.
REQ-030 M and Sts SHALL be purely combinational, and SHALL be valid even when En=0.
REQ-031 The stack SHALL be LIFO; entries above SP are don't-care and SHALL NOT be observable on any output.

Reset
REQ-032 Clr=0 SHALL immediately force State=0, SP=0, Err=0, Empty=1, Full=0, independent of Clk.
REQ-033 Stack entries SHALL clear to 0 on reset.
REQ-034 Deassertion of Clr SHALL take effect at the next rising Clk; the first update uses the inputs present at that edge.
REQ-035 Clr asserted mid-operation, including during a push or pop, SHALL discard that operation entirely.

Verification
REQ-036 Decode sweep: all 8 NS values x Sts 0/1 via Inv with Cond=0 -> M matches the table in REQ-020; State=0xFF with NS=011 -> State 0x00 next cycle.
REQ-037 Call/return: State=0x10, NS=000, Call=1, EncAddr=0x40 -> State=0x40, SP=1; then NS=111, Sts=0 -> State=0x11, SP=0, Err=0.
REQ-038 Overflow: 4 pushes then a 5th with PipeAddr=0x22 -> State=0x22, SP=4, Full=1, Err=1, and 4 subsequent pops return entries in LIFO order.
REQ-039 Underflow: SP=0, NS=111, Sts=0 -> State=0x00, Err=1; Err remains 1 for 10 cycles of normal operation.
REQ-040 Hold/reset: En=0 with NS=010 -> State unchanged; Clr pulsed low mid-cycle with SP=2 -> State=0, SP=0, Err=0 before the next edge.
